// File: rtl/operand_fetch_4x16.sv
// Four-entry register bank with write-to-read bypass and a single-entry
// registered operand stage handed downstream over a valid/ready handshake.
module operand_fetch_4x16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  accept;
  logic                  load_ops;
  logic [DATA_WIDTH-1:0] bank [DEPTH];
  logic [DATA_WIDTH-1:0] val_a;
  logic [DATA_WIDTH-1:0] val_b;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a held pair stays stable
  // until it is transferred. rd_ready = stage empty or being drained now.
  assign op_valid  = (state_q == FULL);
  assign rd_ready  = !op_valid || op_ready;
  assign accept    = rd_valid && rd_ready;
  assign dbg_state = logic'(state_q);

  // A write in the same cycle as a read of the same register wins.
  always_comb begin
    val_a = bank[rd_addr_a];
    val_b = bank[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_a)) val_a = wr_data;
    if (wr_en && (wr_addr == rd_addr_b)) val_b = wr_data;
  end

  always_comb begin
    state_d  = state_q;
    load_ops = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = FULL;
          load_ops = 1'b1;
        end
      end
      FULL: begin
        if (op_ready) begin
          state_d  = accept ? FULL : EMPTY;
          load_ops = accept;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (load_ops) begin
      op_a <= val_a;
      op_b <= val_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_operand_fetch_4x16.sv
// Randomised and directed bench for operand_fetch_4x16 against a
// behavioural model of the bank and the single operand slot.
module tb_operand_fetch_4x16;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [1:0]  rd_addr_a;
  logic [1:0]  rd_addr_b;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        dbg_state;

  int checks;
  int failures;

  // Reference model: register file contents plus the one operand slot.
  logic [15:0] m_reg [4];
  logic        m_valid;
  logic [15:0] m_a;
  logic [15:0] m_b;

  operand_fetch_4x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
    m_valid = 1'b0;
    m_a     = 16'h0000;
    m_b     = 16'h0000;
  endtask

  // Drivers
  task automatic set_in(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                        input logic rv, input logic [1:0] ra, input logic [1:0] rb,
                        input logic ordy);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr_a = ra; rd_addr_b = rb; op_ready = ordy;
    #1;
  endtask

  task automatic tick();
    logic        acc;
    logic [15:0] va;
    logic [15:0] vb;
    @(posedge clk);
    acc = rd_valid && (!m_valid || op_ready);
    va  = (wr_en && wr_addr == rd_addr_a) ? wr_data : m_reg[rd_addr_a];
    vb  = (wr_en && wr_addr == rd_addr_b) ? wr_data : m_reg[rd_addr_b];
    if (acc) begin
      m_valid = 1'b1;
      m_a     = va;
      m_b     = vb;
    end else if (m_valid && op_ready) begin
      m_valid = 1'b0;
    end
    if (wr_en) m_reg[wr_addr] = wr_data;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_valid = 0; rd_addr_a = 0; rd_addr_b = 0; op_ready = 0;
    model_reset();
    #3;
    checks++;
    if (op_valid !== 1'b0 || op_a !== 16'h0000 || op_b !== 16'h0000 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: op_valid=%0b op_a=%h op_b=%h state=%0b, want 0/0000/0000/0",
               op_valid, op_a, op_b, dbg_state);
    end
    checks++;
    if (rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_rd_ready: got %0b want 1", rd_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midstream();
    set_in(1, 2'd0, 16'hC0DE, 0, 2'd0, 2'd0, 0);
    tick();
    set_in(0, 2'd0, 16'h0000, 1, 2'd0, 2'd0, 0);
    tick();
    checks++;
    if (op_valid !== 1'b1 || op_a !== 16'hC0DE) begin
      failures++;
      $display("FAIL midreset_setup: op_valid=%0b op_a=%h want 1/c0de", op_valid, op_a);
    end
    @(negedge clk);
    rd_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (op_valid !== 1'b0 || op_a !== 16'h0000 || op_b !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_async: op_valid=%0b op_a=%h op_b=%h want 0/0000/0000",
               op_valid, op_a, op_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 2'd0, 16'h0000, 1, i[1:0], 2'(3 - i), 1);
      tick();
      checks++;
      if (op_valid !== 1'b1 || op_a !== 16'h0000 || op_b !== 16'h0000) begin
        failures++;
        $display("FAIL midreset_bank%0d: op_valid=%0b op_a=%h op_b=%h want 1/0000/0000",
                 i, op_valid, op_a, op_b);
      end
    end
    set_in(0, 2'd0, 16'h0000, 0, 2'd0, 2'd0, 1);
    tick();
  endtask

  task automatic test_basic();
    set_in(1, 2'd1, 16'h1234, 0, 2'd0, 2'd0, 1);
    tick();
    set_in(1, 2'd2, 16'hABCD, 0, 2'd0, 2'd0, 1);
    tick();
    set_in(0, 2'd0, 16'h0000, 1, 2'd1, 2'd2, 1);
    tick();
    checks++;
    if (op_valid !== 1'b1 || op_a !== 16'h1234 || op_b !== 16'hABCD) begin
      failures++;
      $display("FAIL basic_read: op_valid=%0b op_a=%h op_b=%h want 1/1234/abcd",
               op_valid, op_a, op_b);
    end
  endtask

  task automatic test_bypass();
    set_in(1, 2'd3, 16'h0001, 0, 2'd0, 2'd0, 1);
    tick();
    set_in(1, 2'd3, 16'hBEEF, 1, 2'd3, 2'd3, 1);
    tick();
    checks++;
    if (op_valid !== 1'b1 || op_a !== 16'hBEEF || op_b !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_same: op_valid=%0b op_a=%h op_b=%h want 1/beef/beef",
               op_valid, op_a, op_b);
    end
    set_in(1, 2'd0, 16'h7777, 1, 2'd0, 2'd3, 1);
    tick();
    checks++;
    if (op_a !== 16'h7777 || op_b !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_split: op_a=%h op_b=%h want 7777/beef", op_a, op_b);
    end
  endtask

  task automatic test_stall();
    set_in(1, 2'd1, 16'h1234, 0, 2'd0, 2'd0, 1);
    tick();
    set_in(0, 2'd0, 16'h0000, 1, 2'd1, 2'd1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'd1, 16'h5555, 1, 2'd1, 2'd1, 0);
      checks++;
      if (rd_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_rd_ready%0d: got %0b want 0", i, rd_ready);
      end
      tick();
      checks++;
      if (op_valid !== 1'b1 || op_a !== 16'h1234 || op_b !== 16'h1234 || dbg_state !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: op_valid=%0b op_a=%h op_b=%h state=%0b want 1/1234/1234/1",
                 i, op_valid, op_a, op_b, dbg_state);
      end
    end
    set_in(0, 2'd0, 16'h0000, 1, 2'd1, 2'd0, 1);
    checks++;
    if (rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %0b want 1", rd_ready);
    end
    tick();
    checks++;
    if (op_valid !== 1'b1 || op_a !== 16'h5555) begin
      failures++;
      $display("FAIL stall_refetch: op_valid=%0b op_a=%h want 1/5555", op_valid, op_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = 16'($urandom_range(16'hFFFF, 1));
      set_in(1, i[1:0], v[i], 0, 2'd0, 2'd0, 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 2'd0, 16'h0000, 1, i[1:0], 2'd0, 1);
      tick();
      checks++;
      if (op_valid !== 1'b1 || op_a !== v[i] || op_b !== v[0]) begin
        failures++;
        $display("FAIL b2b_%0d: op_valid=%0b op_a=%h op_b=%h want 1/%h/%h",
                 i, op_valid, op_a, op_b, v[i], v[0]);
      end
    end
    set_in(0, 2'd0, 16'h0000, 0, 2'd0, 2'd0, 1);
    tick();
    checks++;
    if (op_valid !== 1'b0 || op_a !== v[3]) begin
      failures++;
      $display("FAIL b2b_drain: op_valid=%0b op_a=%h want 0/%h", op_valid, op_a, v[3]);
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int n = 0; n < 300; n++) begin
      set_in(1'($urandom_range(1, 0)), 2'($urandom), 16'($urandom),
             1'($urandom_range(3, 0) != 0), 2'($urandom), 2'($urandom),
             1'($urandom_range(2, 0) != 0));
      exp_ready = !m_valid || op_ready;
      checks++;
      if (rd_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_rd_ready@%0d: got %0b want %0b", n, rd_ready, exp_ready);
      end
      tick();
      checks++;
      if (op_valid !== m_valid || op_a !== m_a || op_b !== m_b) begin
        failures++;
        $display("FAIL rand_ops@%0d: op_valid=%0b op_a=%h op_b=%h want %0b/%h/%h",
                 n, op_valid, op_a, op_b, m_valid, m_a, m_b);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
